decode_stage_fwd_pipe: RTL and testbench

//  Next-gen decode stage between the micro-op queue and EXE. Reads SRC_N source operands from the
//  GPR file and resolves forwarding internally by address compare against EXE and WB_LAYERS

---
 rtl/decode_stage_fwd_pipe_if.sv | 39 +++
 rtl/decode_stage_fwd_pipe.sv | 148 ++++++++++++++
 tb/tb_decode_stage_fwd_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_fwd_pipe_if.sv
// Micro-op channel between the queue, decode and EXE: request side (in_*) and decoded side (out_*).
interface decode_stage_fwd_pipe_if #(
  parameter int unsigned SRC_N  = 3,
  parameter int unsigned RA_W   = 4,
  parameter int unsigned REG_W  = 64,
  parameter int unsigned OP_W   = 8,
  parameter int unsigned IMM_W  = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [OP_W-1:0]         in_opcode;
  logic [SRC_N*RA_W-1:0]   in_ra;
  logic [SRC_N-1:0]        in_use;
  logic [IMM_W-1:0]        in_imm;
  logic [1:0]              in_bit_mode;
  logic [ADDR_W-1:0]       in_pc;

  logic                    out_valid;
  logic                    out_ready;
  logic [OP_W-1:0]         out_opcode;
  logic [SRC_N*RA_W-1:0]   out_ra;
  logic [IMM_W-1:0]        out_imm;
  logic [1:0]              out_bit_mode;
  logic [ADDR_W-1:0]       out_pc;
  logic [SRC_N*REG_W-1:0]  out_val;

  // Environment view: feeds micro-ops in, consumes decoded ops.
  modport master (
    output in_valid, in_opcode, in_ra, in_use, in_imm, in_bit_mode, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_ra, out_imm, out_bit_mode, out_pc, out_val
  );

  // Decode stage view.
  modport slave (
    input  in_valid, in_opcode, in_ra, in_use, in_imm, in_bit_mode, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_ra, out_imm, out_bit_mode, out_pc, out_val
  );
endinterface

// File: rtl/decode_stage_fwd_pipe.sv
// Decode stage with internal operand forwarding, load-use stall and a valid/ready output register.
// Optional DECODE_PERF_CNT_EN adds saturating hazard_cnt / flush_cnt performance counters.
module decode_stage_fwd_pipe #(
  parameter int unsigned SRC_N     = 3,
  parameter int unsigned WB_LAYERS = 2,
  parameter int unsigned REG_N     = 16,
  parameter int unsigned RA_W      = 4,
  parameter int unsigned REG_W     = 64,
  parameter int unsigned OP_W      = 8,
  parameter int unsigned IMM_W     = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  decode_stage_fwd_pipe_if.slave     bus,
  input  logic [REG_N*REG_W-1:0]     gpr_flat,
  input  logic                       exe_valid,
  input  logic                       exe_is_load,
  input  logic [RA_W-1:0]            exe_wa,
  input  logic [REG_W-1:0]           exe_d,
  input  logic [WB_LAYERS-1:0]       wri_valid,
  input  logic [WB_LAYERS*RA_W-1:0]  wri_wa,
  input  logic [WB_LAYERS*REG_W-1:0] wri_d,
  input  logic                       flush
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]                hazard_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  localparam int unsigned RA_FLAT_W  = SRC_N * RA_W;
  localparam int unsigned VAL_FLAT_W = SRC_N * REG_W;

  logic                   out_valid_q, valid_nxt;
  logic [OP_W-1:0]        out_opcode_q, opcode_nxt;
  logic [RA_FLAT_W-1:0]   out_ra_q, ra_nxt;
  logic [IMM_W-1:0]       out_imm_q, imm_nxt;
  logic [1:0]             out_bit_mode_q, bit_mode_nxt;
  logic [ADDR_W-1:0]      out_pc_q, pc_nxt;
  logic [VAL_FLAT_W-1:0]  out_val_q, val_nxt;

  logic [VAL_FLAT_W-1:0]  res_flat;
  logic [RA_W-1:0]        ra_k;
  logic [REG_W-1:0]       sel;
  logic                   use_hit;
  logic                   hazard;
  logic                   in_ready;
  logic                   capture;

  // Operand resolution: EXE beats youngest WB layer, which beats older layers, which beat the GPR file.
  always_comb begin
    res_flat = '0;
    ra_k     = '0;
    sel      = '0;
    for (int unsigned k = 0; k < SRC_N; k++) begin
      ra_k = bus.in_ra[k*RA_W +: RA_W];
      sel  = '0;
      for (int unsigned r = 0; r < REG_N; r++) begin
        if (ra_k == RA_W'(r)) sel = gpr_flat[r*REG_W +: REG_W];
      end
      for (int l = int'(WB_LAYERS) - 1; l >= 0; l--) begin
        if (wri_valid[l] && (wri_wa[l*RA_W +: RA_W] == ra_k)) sel = wri_d[l*REG_W +: REG_W];
      end
      if (exe_valid && (exe_wa == ra_k)) sel = exe_d;
      res_flat[k*REG_W +: REG_W] = sel;
    end
  end

  // Load-use: only ports the op really reads can stall it.
  always_comb begin
    use_hit = 1'b0;
    for (int unsigned k = 0; k < SRC_N; k++) begin
      if (bus.in_use[k] && (exe_wa == bus.in_ra[k*RA_W +: RA_W])) use_hit = 1'b1;
    end
  end

  assign hazard   = bus.in_valid & exe_valid & exe_is_load & use_hit;
  assign in_ready = (~out_valid_q | bus.out_ready) & ~hazard & ~flush;
  assign capture  = bus.in_valid & in_ready;

  // Output register next state; flush dominates capture and hold.
  always_comb begin
    valid_nxt    = out_valid_q;
    opcode_nxt   = out_opcode_q;
    ra_nxt       = out_ra_q;
    imm_nxt      = out_imm_q;
    bit_mode_nxt = out_bit_mode_q;
    pc_nxt       = out_pc_q;
    val_nxt      = out_val_q;
    if (flush) begin
      valid_nxt = 1'b0;
    end else if (capture) begin
      valid_nxt    = 1'b1;
      opcode_nxt   = bus.in_opcode;
      ra_nxt       = bus.in_ra;
      imm_nxt      = bus.in_imm;
      bit_mode_nxt = bus.in_bit_mode;
      pc_nxt       = bus.in_pc;
      val_nxt      = res_flat;
    end else if (bus.out_ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q    <= 1'b0;
      out_opcode_q   <= '0;
      out_ra_q       <= '0;
      out_imm_q      <= '0;
      out_bit_mode_q <= '0;
      out_pc_q       <= '0;
      out_val_q      <= '0;
    end else begin
      out_valid_q    <= valid_nxt;
      out_opcode_q   <= opcode_nxt;
      out_ra_q       <= ra_nxt;
      out_imm_q      <= imm_nxt;
      out_bit_mode_q <= bit_mode_nxt;
      out_pc_q       <= pc_nxt;
      out_val_q      <= val_nxt;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = out_opcode_q;
  assign bus.out_ra       = out_ra_q;
  assign bus.out_imm      = out_imm_q;
  assign bus.out_bit_mode = out_bit_mode_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_val      = out_val_q;

`ifdef DECODE_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hazard_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (hazard && (hazard_cnt != 32'hFFFF_FFFF)) hazard_cnt <= hazard_cnt + 32'd1;
      if (flush && out_valid_q && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_fwd_pipe.sv
// Directed bench for decode_stage_fwd_pipe: vector table plus hold/flush/hazard/reset sequences.
module tb_decode_stage_fwd_pipe;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1023:0] gpr_flat;
  logic          exe_valid, exe_is_load;
  logic [3:0]    exe_wa;
  logic [63:0]   exe_d;
  logic [1:0]    wri_valid;
  logic [7:0]    wri_wa;
  logic [127:0]  wri_d;
  logic          flush;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]   hazard_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  decode_stage_fwd_pipe_if bus ();

  decode_stage_fwd_pipe dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .gpr_flat   (gpr_flat),
    .exe_valid  (exe_valid),
    .exe_is_load(exe_is_load),
    .exe_wa     (exe_wa),
    .exe_d      (exe_d),
    .wri_valid  (wri_valid),
    .wri_wa     (wri_wa),
    .wri_d      (wri_d),
    .flush      (flush)
`ifdef DECODE_PERF_CNT_EN
    ,
    .hazard_cnt (hazard_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic [11:0] ra;
    logic [2:0]  uses;
    logic        ev, el;
    logic [3:0]  ewa;
    logic [63:0] ed;
    logic [1:0]  wv;
    logic [3:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic        fl;
    logic        e_rdy, e_ov;
    logic [63:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(logic iv, logic [11:0] ra, logic [2:0] uses, logic ev, logic el,
                              logic [3:0] ewa, logic [63:0] ed, logic [1:0] wv, logic [3:0] wa0,
                              logic [3:0] wa1, logic [63:0] wd0, logic [63:0] wd1, logic fl,
                              logic e_rdy, logic e_ov, logic [63:0] e0, logic [63:0] e1,
                              logic [63:0] e2);
    vec_t v;
    v.iv = iv; v.ra = ra; v.uses = uses; v.ev = ev; v.el = el; v.ewa = ewa; v.ed = ed;
    v.wv = wv; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1; v.fl = fl;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_ra = '0; bus.in_use = '0;
    bus.in_imm = '0; bus.in_bit_mode = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
    exe_valid = 1'b0; exe_is_load = 1'b0; exe_wa = '0; exe_d = '0;
    wri_valid = '0; wri_wa = '0; wri_d = '0; flush = 1'b0;
  endtask

  task automatic set_gpr_default();
    for (int r = 0; r < 16; r++) gpr_flat[r*64 +: 64] = 64'(r + 2);
  endtask

  function automatic logic [63:0] oval(int k);
    return bus.out_val[k*64 +: 64];
  endfunction

  initial begin
    vecs[0] = mk(1, {4'd0, 4'd3, 4'd1}, 3'b000, 0, 0, 4'd0, 64'h0, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 0, 1, 1, 64'd3, 64'd5, 64'd2);
    vecs[1] = mk(1, {4'd0, 4'd3, 4'd1}, 3'b000, 1, 0, 4'd3, 64'd9, 2'b01, 4'd3, 4'd0, 64'd7, 64'h0, 0, 1, 1, 64'd3, 64'd9, 64'd2);
    vecs[2] = mk(1, {4'd1, 4'd5, 4'd1}, 3'b000, 0, 0, 4'd0, 64'h0, 2'b11, 4'd1, 4'd1, 64'h70, 64'h71, 0, 1, 1, 64'h70, 64'd7, 64'h70);
    vecs[3] = mk(1, {4'd3, 4'd2, 4'd1}, 3'b000, 0, 0, 4'd0, 64'h0, 2'b10, 4'd1, 4'd1, 64'h70, 64'h71, 0, 1, 1, 64'h71, 64'd4, 64'd5);
    vecs[4] = mk(1, {4'd2, 4'd2, 4'd2}, 3'b111, 0, 1, 4'd2, 64'hAA, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 0, 1, 1, 64'd4, 64'd4, 64'd4);
    vecs[5] = mk(1, {4'd2, 4'd0, 4'd0}, 3'b100, 1, 1, 4'd2, 64'hBB, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 64'h0);
    vecs[6] = mk(1, {4'd2, 4'd1, 4'd0}, 3'b011, 1, 1, 4'd2, 64'hBB, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 0, 1, 1, 64'd2, 64'd3, 64'hBB);
    vecs[7] = mk(1, {4'd0, 4'd0, 4'd0}, 3'b000, 0, 0, 4'd0, 64'h0, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 1, 0, 0, 64'h0, 64'h0, 64'h0);
    vecs[8] = mk(0, {4'd0, 4'd0, 4'd0}, 3'b000, 0, 0, 4'd0, 64'h0, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 0, 1, 0, 64'h0, 64'h0, 64'h0);
    vecs[9] = mk(1, {4'd0, 4'd14, 4'd15}, 3'b000, 0, 0, 4'd0, 64'h0, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 0, 1, 1, 64'd17, 64'd16, 64'd2);

    rstn = 1'b0;
    idle_inputs();
    set_gpr_default();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_val_s", oval(1), 64'd0);
    chk("reset_out_pc", 64'(bus.out_pc), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table: drive at posedge+1, check in_ready at posedge+4, outputs at next posedge+1.
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = vecs[i].iv; bus.in_ra = vecs[i].ra; bus.in_use = vecs[i].uses;
      bus.in_opcode = 8'(8'h10 + i); bus.in_imm = 32'(i * 32'h111); bus.in_bit_mode = 2'(i);
      bus.in_pc = 32'(32'h1000 + 4 * i); bus.out_ready = 1'b1;
      exe_valid = vecs[i].ev; exe_is_load = vecs[i].el; exe_wa = vecs[i].ewa; exe_d = vecs[i].ed;
      wri_valid = vecs[i].wv; wri_wa = {vecs[i].wa1, vecs[i].wa0}; wri_d = {vecs[i].wd1, vecs[i].wd0};
      flush = vecs[i].fl;
      #3;
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_val_d", i), oval(0), vecs[i].e0);
        chk($sformatf("v%0d_val_s", i), oval(1), vecs[i].e1);
        chk($sformatf("v%0d_val_t", i), oval(2), vecs[i].e2);
        chk($sformatf("v%0d_opcode", i), 64'(bus.out_opcode), 64'(8'h10 + i));
        chk($sformatf("v%0d_pc", i), 64'(bus.out_pc), 64'(32'h1000 + 4 * i));
        chk($sformatf("v%0d_imm", i), 64'(bus.out_imm), 64'(i * 32'h111));
        chk($sformatf("v%0d_ra", i), 64'(bus.out_ra), 64'(vecs[i].ra));
      end
    end

    // Drain, then capture an op that will be back-pressured.
    idle_inputs();
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_opcode = 8'hA1; bus.in_ra = {4'd3, 4'd3, 4'd3};
    bus.in_pc = 32'h2000; bus.out_ready = 1'b0;
    #3;
    chk("hold_cap_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("hold_cap_valid", 64'(bus.out_valid), 64'd1);
    bus.in_opcode = 8'hB2; bus.in_ra = {4'd1, 4'd1, 4'd1}; bus.in_pc = 32'h2004;
    gpr_flat[3*64 +: 64] = 64'h99;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk($sformatf("hold%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("hold%0d_opcode", c), 64'(bus.out_opcode), 64'hA1);
      chk($sformatf("hold%0d_val_s", c), oval(1), 64'd5);
      chk($sformatf("hold%0d_pc", c), 64'(bus.out_pc), 64'h2000);
    end
    set_gpr_default();
    bus.out_ready = 1'b1;
    #3;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("release_opcode", 64'(bus.out_opcode), 64'hB2);
    chk("release_val_d", oval(0), 64'd3);

    // Flush beats hold and capture.
    bus.out_ready = 1'b0; bus.in_opcode = 8'hC3; flush = 1'b1;
    #3;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    flush = 1'b0;

    // Load-use stall then forward from WB0 once the load moves on.
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_opcode = 8'hD4; bus.in_ra = {4'd2, 4'd0, 4'd0}; bus.in_use = 3'b100;
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_wa = 4'd2; exe_d = 64'hDEAD;
    #3;
    chk("lu_stall_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("lu_stall_out_valid", 64'(bus.out_valid), 64'd0);
    exe_valid = 1'b0; exe_is_load = 1'b0;
    wri_valid = 2'b01; wri_wa = {4'd0, 4'd2}; wri_d = {64'h0, 64'h11};
    #3;
    chk("lu_go_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("lu_go_out_valid", 64'(bus.out_valid), 64'd1);
    chk("lu_go_val_t", oval(2), 64'h11);
    chk("lu_go_opcode", 64'(bus.out_opcode), 64'hD4);

    // Reset while holding drops the output immediately.
    idle_inputs();
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_val_t", oval(2), 64'd0);
    chk("rst_mid_opcode", 64'(bus.out_opcode), 64'd0);
`ifdef DECODE_PERF_CNT_EN
    chk("rst_hazard_cnt", 64'(hazard_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
